// File: rtl/lz77_decoder_if.sv
// Triplet-in / character-out bundle between a triplet source and the LZ77 decoder.
// The master drives triplets and observes the decoded stream; the slave is the decoder.
interface lz77_decoder_if #(
  parameter int DATA_W = 8,
  parameter int OFF_W  = 4,
  parameter int LEN_W  = 3
) ();
  logic              in_valid;
  logic              in_ready;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  match_len;
  logic [DATA_W-1:0] char_nxt;
  logic              out_valid;
  logic [DATA_W-1:0] char_out;
  logic              finish;

  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, char_out, finish
  );

  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, char_out, finish
  );
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, match_len, char_nxt) triplets into one character per cycle
// using a shifting search buffer; an END_CHAR literal clears the buffer and pulses finish.
module lz77_decoder #(
  parameter int                DATA_W       = 8,
  parameter int                SEARCH_DEPTH = 9,
  parameter int                OFF_W        = 4,
  parameter int                LEN_W        = 3,
  parameter logic [DATA_W-1:0] END_CHAR     = 8'h24
) (
  input  logic           clk,
  input  logic           reset,
  lz77_decoder_if.slave  bus
);

  typedef enum logic {IDLE, COPY} state_t;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [OFF_W-1:0]  off_reg, off_next;
  logic [DATA_W-1:0] chr_reg, chr_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] char_out_reg, char_out_next;
  logic              finish_reg, finish_next;

  logic [DATA_W-1:0] hist_reg [SEARCH_DEPTH];
  logic              shift_en;
  logic              hist_clr;
  logic [DATA_W-1:0] shift_in;
  logic              off_in_range;
  logic [OFF_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_char;

  // Out-of-range offsets read as zero instead of indexing past the buffer.
  assign off_in_range = 32'(off_reg) < 32'(SEARCH_DEPTH);
  assign rd_idx       = off_in_range ? off_reg : '0;
  assign rd_char      = off_in_range ? hist_reg[rd_idx] : '0;

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.char_out  = char_out_reg;
  assign bus.finish    = finish_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      off_reg       <= '0;
      chr_reg       <= '0;
      out_valid_reg <= 1'b0;
      char_out_reg  <= '0;
      finish_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      off_reg       <= off_next;
      chr_reg       <= chr_next;
      out_valid_reg <= out_valid_next;
      char_out_reg  <= char_out_next;
      finish_reg    <= finish_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    off_next       = off_reg;
    chr_next       = chr_reg;
    out_valid_next = 1'b0;
    char_out_next  = char_out_reg;
    finish_next    = 1'b0;
    shift_en       = 1'b0;
    hist_clr       = 1'b0;
    shift_in       = rd_char;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          off_next   = bus.offset;
          cnt_next   = bus.match_len;
          chr_next   = bus.char_nxt;
          state_next = COPY;
        end
      end
      COPY: begin
        if (cnt_reg != '0) begin
          // Copied char is pushed back in, so overlapping matches re-read it.
          char_out_next  = rd_char;
          out_valid_next = 1'b1;
          shift_en       = 1'b1;
          shift_in       = rd_char;
          cnt_next       = cnt_reg - 1'b1;
        end else if (chr_reg == END_CHAR) begin
          finish_next = 1'b1;
          hist_clr    = 1'b1;
          state_next  = IDLE;
        end else begin
          char_out_next  = chr_reg;
          out_valid_next = 1'b1;
          shift_en       = 1'b1;
          shift_in       = chr_reg;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Search buffer: entry 0 holds the newest char, each entry takes its neighbour on a shift.
  genvar gi;
  generate
    for (gi = 0; gi < SEARCH_DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset || hist_clr) begin
            hist_reg[gi] <= '0;
          end else if (shift_en) begin
            hist_reg[gi] <= shift_in;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset || hist_clr) begin
            hist_reg[gi] <= '0;
          end else if (shift_en) begin
            hist_reg[gi] <= hist_reg[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_lz77_decoder.sv
// Bench for lz77_decoder: directed and random triplets, a stream-based reference model
// feeding an expectation queue, and a negedge monitor that pops and compares outputs.
module tb_lz77_decoder;
  localparam int         DATA_W       = 8;
  localparam int         SEARCH_DEPTH = 9;
  localparam int         OFF_W        = 4;
  localparam int         LEN_W        = 3;
  localparam logic [7:0] END_CHAR     = 8'h24;

  typedef struct {
    bit         is_fin;
    logic [7:0] ch;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   mon_en;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] stream[$];

  lz77_decoder_if #(.DATA_W(DATA_W), .OFF_W(OFF_W), .LEN_W(LEN_W)) bus ();

  lz77_decoder #(
    .DATA_W(DATA_W), .SEARCH_DEPTH(SEARCH_DEPTH), .OFF_W(OFF_W),
    .LEN_W(LEN_W), .END_CHAR(END_CHAR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference: the decoded text since the last clear; offset k names the k-th newest char.
  function automatic logic [7:0] ref_read(int off);
    if (off < SEARCH_DEPTH && off < stream.size())
      return stream[stream.size() - 1 - off];
    return 8'h00;
  endfunction

  function automatic void ref_emit(logic [7:0] c);
    exp_t e;
    stream.push_back(c);
    if (stream.size() > 2 * SEARCH_DEPTH) void'(stream.pop_front());
    e.is_fin = 1'b0;
    e.ch     = c;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_en && (bus.out_valid === 1'b1 || bus.finish === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(bus.char_out), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_kind_finish", 32'(bus.finish), 32'(mon_e.is_fin));
        if (mon_e.is_fin) chk("finish_valid_low", 32'(bus.out_valid), 32'd0);
        else              chk("char_out", 32'(bus.char_out), 32'(mon_e.ch));
      end
    end
  end

  // Called at a negedge with the decoder idle; returns at the negedge it is idle again.
  task automatic send(input int off, input int len, input logic [7:0] ch);
    exp_t e;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.offset    = 4'(off);
    bus.match_len = 3'(len);
    bus.char_nxt  = ch;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < len; k++) ref_emit(ref_read(off));
    if (ch == END_CHAR) begin
      e.is_fin = 1'b1;
      e.ch     = 8'h00;
      exp_q.push_back(e);
      stream.delete();
    end else begin
      ref_emit(ch);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      chk("out_valid_timing", 32'(bus.out_valid), (i == 0) ? 32'd0 : 32'd1);
      bus.in_valid  = 1'($urandom);
      bus.offset    = 4'($urandom);
      bus.match_len = 3'($urandom);
      bus.char_nxt  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    if (ch == END_CHAR) chk("finish_pulse", 32'(bus.finish), 32'd1);
    else                chk("last_out_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stream.delete();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_char_out", 32'(bus.char_out), 32'd0);
    chk("rst_finish", 32'(bus.finish), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int off, len;
    logic [7:0] ch;
    checks        = 0;
    failures      = 0;
    mon_en        = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.offset    = '0;
    bus.match_len = '0;
    bus.char_nxt  = '0;
    apply_reset(2);
    mon_en = 1'b1;

    send(0, 0, 8'h0A);
    send(0, 0, 8'h01); send(0, 0, 8'h02); send(0, 0, 8'h03);
    send(2, 3, 8'h04);
    send(0, 0, 8'h05); send(0, 4, 8'h06); send(4, 1, 8'h00);
    send(0, 0, 8'h07); send(0, 0, 8'h08); send(1, 2, END_CHAR);
    send(3, 1, 8'h01);
    send(12, 2, 8'h33);
    send(8, 3, END_CHAR);

    // Abort mid-copy: fill the buffer, then reset after two copied chars.
    send(0, 0, 8'h5A); send(0, 7, 8'h5B); send(1, 2, 8'h5C);
    bus.offset = 4'd0; bus.match_len = 3'd7; bus.char_nxt = 8'h77; bus.in_valid = 1'b1;
    ref_emit(ref_read(0));
    ref_emit(ref_read(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk); chk("abort_bubble", 32'(bus.out_valid), 32'd0);
    @(negedge clk); chk("abort_char1_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); chk("abort_char2_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stream.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    send(0, 1, 8'h11);
    send(8, 2, 8'h12);

    for (int n = 0; n < 160; n++) begin
      off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
      len = $urandom_range(0, 7);
      ch  = ($urandom_range(0, 7) == 0) ? END_CHAR : 8'($urandom);
      send(off, len, ch);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
